// File: rtl/attention_pkg.sv
// attention_pkg: shared state encoding, width helpers and default shift for attention_tile
package attention_pkg;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    localparam int VALUE_SHIFT_DEF = 8;

    function automatic int acc_width(input int dw, input int k_max);
        return 3 * dw + $clog2(k_max) + 1;
    endfunction

    function automatic int klen_width(input int k_max);
        return $clog2(k_max + 1);
    endfunction

endpackage

// File: rtl/attention_lane.sv
// attention_lane: one lane of q*k*v accumulate, arithmetic shift and width reduction
// ATTN_TILE_SATURATE_EN selects clipping with a sat flag instead of two's-complement wrap
module attention_lane import attention_pkg::*; #(
    parameter int DATA_WIDTH  = 16,
    parameter int K_MAX       = 64,
    parameter int VALUE_SHIFT = VALUE_SHIFT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [DATA_WIDTH-1:0] k,
    input  logic [DATA_WIDTH-1:0] v,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  sat
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = acc_width(DW, K_MAX);

    logic [2*DW-1:0]        qk;
    logic [3*DW-1:0]        qkv;
    logic [AW-1:0]          acc;
    logic [AW-1:0]          acc_n;
    logic signed [AW-1:0]   shifted;
    logic [DW-1:0]          red;
    logic                   red_sat;

    // operands are sign-extended to full product width so the low bits are the signed product
    assign qk      = {{DW{q[DW-1]}}, q} * {{DW{k[DW-1]}}, k};
    assign qkv     = {{DW{qk[2*DW-1]}}, qk} * {{(2*DW){v[DW-1]}}, v};
    assign acc_n   = clr ? '0 : en ? acc + {{(AW-3*DW){qkv[3*DW-1]}}, qkv} : acc;
    assign shifted = $signed(acc_n) >>> VALUE_SHIFT;

`ifdef ATTN_TILE_SATURATE_EN
    localparam logic signed [AW-1:0] HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] LO = ~HI;

    assign red_sat = shifted > HI || shifted < LO;
    assign red     = shifted > HI ? HI[DW-1:0] : shifted < LO ? LO[DW-1:0] : shifted[DW-1:0];
`else
    logic unused_hi;

    assign unused_hi = ^shifted[AW-1:DW];
    assign red_sat   = 1'b0;
    assign red       = shifted[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
            sat    <= 1'b0;
        end else begin
            acc <= acc_n;
            if (load) begin
                result <= red;
                sat    <= red_sat;
            end
        end
    end

endmodule

// File: rtl/attention_tile.sv
// attention_tile: LANES-wide runtime-length sum(q*k*v) accumulator with valid/ready result
// ATTN_TILE_SATURATE_EN enables per-lane saturation and out_sat
module attention_tile import attention_pkg::*; #(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 4,
    parameter int K_MAX       = 64,
    parameter int VALUE_SHIFT = VALUE_SHIFT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [$clog2(K_MAX+1)-1:0]    cfg_k_len,
    output logic                          cfg_ready,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   q_data,
    input  logic [LANES*DATA_WIDTH-1:0]   k_data,
    input  logic [LANES*DATA_WIDTH-1:0]   v_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_sat,
    output logic                          busy
);
    localparam int KW = klen_width(K_MAX);

    state_t          state;
    state_t          state_n;
    logic [KW-1:0]   k_len;
    logic [KW-1:0]   cnt;
    logic [KW-1:0]   len_c;
    logic            accept;
    logic            beat;
    logic            last;
    logic            load;

    assign len_c     = cfg_k_len > KW'(K_MAX) ? KW'(K_MAX) : cfg_k_len;
    assign cfg_ready = state == IDLE || (state == OUT && out_ready);
    assign accept    = cfg_start && cfg_ready;
    assign in_ready  = state == RUN;
    assign beat      = in_valid && in_ready;
    assign last      = beat && cnt == k_len - 1'b1;
    // a zero-length start loads the freshly cleared (zero) accumulators straight into the outputs
    assign load      = last || (accept && len_c == '0);
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;

    always_comb begin
        state_n = state;
        if (accept)
            state_n = len_c == '0 ? OUT : RUN;
        else if (last)
            state_n = OUT;
        else if (state == OUT && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k_len <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                k_len <= len_c;
                cnt   <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        attention_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .K_MAX       (K_MAX),
            .VALUE_SHIFT (VALUE_SHIFT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (accept),
            .en     (beat),
            .load   (load),
            .q      (q_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .k      (k_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .v      (v_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .result (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .sat    (out_sat[i])
        );
    end

endmodule

// File: tb/tb_attention_tile.sv
// tb_attention_tile: randomized scoreboard bench for attention_tile against a sum-of-products model
module tb_attention_tile;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int KM = 64;
    localparam int VS = 8;
    localparam int KW = $clog2(KM + 1);

    typedef struct {
        logic [L*DW-1:0] d;
        logic [L-1:0]    s;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_start = 1'b0;
    logic [KW-1:0]   cfg_k_len = '0;
    logic            cfg_ready;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [L*DW-1:0] q_data = '0;
    logic [L*DW-1:0] k_data = '0;
    logic [L*DW-1:0] v_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [L*DW-1:0] out_data;
    logic [L-1:0]    out_sat;
    logic            busy;

    int checks = 0;
    int passes = 0;
    int ready_pct = 100;
    bit hold_low = 1'b0;
    exp_t sb[$];
    logic [L*DW-1:0] qa[$];
    logic [L*DW-1:0] ka[$];
    logic [L*DW-1:0] va[$];

    attention_tile #(.DATA_WIDTH(DW), .LANES(L), .K_MAX(KM), .VALUE_SHIFT(VS)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_k_len(cfg_k_len), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .q_data(q_data), .k_data(k_data), .v_data(v_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // reference: plain signed sums per lane, then shift and either clip or keep the low bits
    function automatic exp_t model(input int n);
        exp_t e;
        logic [L*DW-1:0] tq, tk, tv;
        longint acc, r;
        e.d = '0;
        e.s = '0;
        for (int l = 0; l < L; l++) begin
            acc = 0;
            for (int b = 0; b < n; b++) begin
                tq = qa[b];
                tk = ka[b];
                tv = va[b];
                acc += longint'($signed(tq[l*DW +: DW])) * longint'($signed(tk[l*DW +: DW]))
                       * longint'($signed(tv[l*DW +: DW]));
            end
            r = acc >>> VS;
`ifdef ATTN_TILE_SATURATE_EN
            if (r > 32767) begin r = 32767; e.s[l] = 1'b1; end
            else if (r < -32768) begin r = -32768; e.s[l] = 1'b1; end
`endif
            e.d[l*DW +: DW] = r[DW-1:0];
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] gen(input int mode, input int l, input logic [DW-1:0] c);
        if (mode == 0) return DW'($urandom);
        if (mode == 1) return DW'($urandom_range(255)) - 16'd128;
        if (mode == 2) return l == 0 ? c : '0;
        return c;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = !hold_low && ($urandom_range(99) < ready_pct);
        end
    end

    logic [L*DW-1:0] held_d;
    logic [L-1:0]    held_s;
    bit              held = 1'b0;
    exp_t            e_mon;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("out_valid_held", out_valid, 1);
                check("out_data_stable", out_data, held_d);
                check("out_sat_stable", out_sat, held_s);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    e_mon = sb.pop_front();
                    check("out_data", out_data, e_mon.d);
                    check("out_sat", out_sat, e_mon.s);
                end
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_d = out_data;
                held_s = out_sat;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic do_run(input int len, input int mode, input int vpct,
                          input logic [DW-1:0] cq, input logic [DW-1:0] ck, input logic [DW-1:0] cv,
                          input bit b2b);
        int eff, got, cyc;
        bit ok;
        logic [L*DW-1:0] tq, tk, tv;
        eff = len > KM ? KM : len;
        qa.delete(); ka.delete(); va.delete();
        for (int b = 0; b < eff; b++) begin
            for (int l = 0; l < L; l++) begin
                tq[l*DW +: DW] = gen(mode, l, cq);
                tk[l*DW +: DW] = gen(mode, l, ck);
                tv[l*DW +: DW] = gen(mode, l, cv);
            end
            qa.push_back(tq); ka.push_back(tk); va.push_back(tv);
        end
        sb.push_back(model(eff));
        cfg_start = 1'b1;
        cfg_k_len = KW'(len);
        cyc = 0;
        while (!cfg_ready && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        ok = cfg_ready;
        check("start_accepted", ok, 1);
        if (b2b) check("b2b_no_bubble", cyc, 0);
        @(posedge clk);
        #1 cfg_start = 1'b0;
        cfg_k_len = KW'($urandom);
        got = 0;
        cyc = 0;
        while (got < eff && cyc < 5000) begin
            in_valid = $urandom_range(99) < vpct;
            q_data = in_valid ? qa[got] : {$urandom, $urandom};
            k_data = in_valid ? ka[got] : {$urandom, $urandom};
            v_data = in_valid ? va[got] : {$urandom, $urandom};
            @(negedge clk);
            if (b2b && cyc == 0) check("b2b_in_ready", in_ready, 1);
            if (in_valid && in_ready) got++;
            @(posedge clk);
            #1 cyc++;
        end
        in_valid = 1'b1;
        q_data = {$urandom, $urandom};
        check("beats_accepted", got, eff);
        @(negedge clk);
        check("out_valid_latency", out_valid, 1);
        check("in_ready_after_last", in_ready, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;

        do_run(4, 2, 100, 16'd2, 16'd2, 16'd2, 0);
        do_run(4, 2, 100, 16'd16, 16'd16, 16'd1, 0);
        drain();

        hold_low = 1'b1;
        do_run(4, 2, 50, 16'd16, 16'd16, 16'd1, 0);
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
        end
        hold_low = 1'b0;
        drain();

        do_run(0, 1, 100, '0, '0, '0, 0);
        do_run(KM + 5, 1, 80, '0, '0, '0, 0);
        do_run(1, 0, 100, '0, '0, '0, 0);
        drain();

        do_run(2, 3, 100, 16'h7fff, 16'h7fff, 16'h7fff, 0);
        do_run(2, 3, 100, 16'h8000, 16'h7fff, 16'h7fff, 0);
        drain();

        do_run(5, 1, 100, '0, '0, '0, 0);
        do_run(3, 1, 100, '0, '0, '0, 1);
        do_run(0, 1, 100, '0, '0, '0, 1);
        drain();

        cfg_start = 1'b1;
        cfg_k_len = KW'(8);
        cyc = 0;
        while (!cfg_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 cfg_start = 1'b0;
        repeat (3) begin
            in_valid = 1'b1;
            q_data = {$urandom, $urandom};
            k_data = {$urandom, $urandom};
            v_data = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        check("midrst_out_data", out_data, 0);
        do_run(8, 1, 100, '0, '0, '0, 0);
        drain();

        ready_pct = 60;
        for (int r = 0; r < 30; r++) begin
            do_run(($urandom_range(9) == 0) ? $urandom_range(KM + 10) : $urandom_range(12),
                   $urandom_range(1), 70, '0, '0, '0, 0);
        end
        ready_pct = 100;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/attention_tile.md
# attention_tile

Multi-lane, runtime-length successor to the single-lane attention accumulator. Each of `LANES` parallel lanes accumulates `sum(q*k*v)` over a run-time-configured number of beats, up to `K_MAX`. The block then presents one shifted, width-reduced result per lane on a valid/ready output. It sits between the Q/K/V stream fetchers and the attention output writer, one instance per head group.

## Interface
Parameters:
- `DATA_WIDTH`, 16: signed element width of q/k/v and of each output lane.
- `LANES`, 4: number of parallel lanes; must be ≥ 1.
- `K_MAX`, 64: maximum beats per run; must be ≥ 1.
- `VALUE_SHIFT`, 8: arithmetic right shift applied to each accumulator before width reduction.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  start a run. Sampled in IDLE, or in OUT together with `out_ready`.
- `cfg_k_len`  in  `$clog2(K_MAX+1)`  beats for this run. Latched when `cfg_start` is accepted.
- `cfg_ready`  out  1  high when `cfg_start` would be accepted this cycle.
- `in_valid`  in  1  Q/K/V beat valid.
- `in_ready`  out  1  high only in RUN.
- `q_data`, `k_data`, `v_data`  in  `LANES*DATA_WIDTH` each  lane i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`, signed.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  `LANES*DATA_WIDTH`  per-lane result, same packing as the inputs.
- `out_sat`  out  `LANES`  per-lane flag: result was clipped. Always 0 when saturation is compiled out.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, OUT.
- IDLE:
  - `cfg_ready`=1.
  - On `cfg_start`, clear all accumulators and the beat counter, then latch `cfg_k_len`:
    - If the value is > `K_MAX`, it is clamped to `K_MAX`.
    - If the value is 0, go directly to OUT with all-zero results and `out_sat`=0.
    - Otherwise go to RUN.
- RUN:
  - Each accepted beat (`in_valid && in_ready`): every lane adds `q*k*v` to its accumulator and the counter increments.
  - On the beat where counter = `k_len-1`, go to OUT and register the outputs.
  - `cfg_start` is ignored in RUN.
- OUT:
  - `out_data`/`out_sat` are held stable until `out_valid && out_ready`.
  - On that handshake:
    - Without `cfg_start`: go to IDLE.
    - With `cfg_start` in the same cycle: clear accumulators, latch the new `cfg_k_len`, and enter RUN (or re-enter OUT if the new length is 0). This gives back-to-back runs with no IDLE bubble.
  - `cfg_ready` = `out_ready` in OUT.
- Arithmetic, per lane:
  - `qk` is a 2·DW signed product; `qkv` is a 3·DW signed product.
  - The accumulator is 3·DW + `$clog2(K_MAX)+1` bits, so it never overflows.
  - `result = acc >>> VALUE_SHIFT`, then reduced to DW bits (see Configuration).
- Reset: at the next `clk` edge with `rst`=1, the block returns to IDLE regardless of state, including mid-RUN and while OUT is stalled. The partial run is discarded with no output.
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `busy`=0, `in_ready`=0, `cfg_ready`=1. Accumulators and counter are 0.
- X on the data inputs while `in_valid`=0 must not propagate into the accumulators.

## Timing
- `in_ready` and `cfg_ready` are combinational from state and `out_ready` only. There is no combinational path from `in_valid` to `in_ready`.
- Latency: the final beat is accepted at edge N; `out_valid`=1 with correct data after edge N.
- `cfg_k_len`=0: `cfg_start` at edge N gives `out_valid` after edge N.
- Throughput: one beat per cycle in RUN. A run of L beats occupies L+1 cycles minimum under back-to-back starts.
- `in_valid` gaps stall the run without losing state.
- `out_valid` never drops without a handshake.

## Configuration
- `ATTN_TILE_SATURATE_EN` defined:
  - A shifted value outside `[-2^(DW-1), 2^(DW-1)-1]` clips to the nearest bound and sets that lane's `out_sat`.
- Not defined:
  - Results are the low DW bits of the shifted value (two's-complement wrap), and `out_sat` is tied to 0.

## Structure
- Package `attention_pkg`:
  - `state_t` enum (IDLE/RUN/OUT).
  - Width helper functions for the accumulator width and the k_len width.
  - The shared `VALUE_SHIFT` default.
- Sub-module `attention_lane`:
  - One lane's multiply, accumulate, shift and reduce (including the saturate option).
  - Instantiated `LANES` times in a generate loop.
  - The FSM and counter live in the top.

## Test plan
- **Basic run:** LANES=4, k_len=4; lane0 q=k=v=2 per beat, other lanes 0. Expect `out_data` lane0 = 32>>>8 = 0; with q=16,k=16,v=1 ×4 beats, lane0 = 1024>>>8 = 4.
- **Back-pressure and gaps:** `in_valid` toggled 1/0 and `out_ready` held low 5 cycles. Expect the same result as the gap-free run, `out_data` stable throughout, and a single handshake.
- **Length boundaries:**
  - k_len=0: `out_valid` 1 cycle after start, data 0.
  - k_len=K_MAX+5: clamped, exactly K_MAX beats accepted.
  - k_len=1: one beat.
- **Saturation:** q=k=v=32767, k_len=2. With the macro, lane = 32767 and `out_sat`=1. Without it, the lane equals the low 16 bits of `(2·32767³)>>>8` and `out_sat`=0. Negative case: q=-32768 gives -32768 with the flag set.
- **Back-to-back:** `cfg_start` asserted with the `out_ready` handshake. Expect no IDLE cycle, `in_ready` high the next cycle, and a correct second result.
- **Reset mid-run:** `rst` after 3 of 8 beats. Expect IDLE next cycle, `out_valid` never asserted, and a fresh run afterwards that is unaffected by stale accumulators.
